seq_tx: RTL and testbench

- Serial frame transmitter; the transmit end of the team's single-bit "0011" sync-pattern link.
- Accepts a parallel payload word through a valid/ready handshake.
- Drives one frame per word onto a 1-bit line: the 4-bit preamble 0011, then the payload MSB-first.
- Line idles high, so a downstream 0011 detector sits in its reset state between frames.

---
 rtl/seq_link_pkg.sv | 23 ++
 rtl/seq_tx_shift.sv | 38 +++
 rtl/seq_tx.sv | 132 +++++++++++++
 tb/tb_seq_tx.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_link_pkg.sv
// Shared definitions for the "0011" sync-pattern serial link: transmitter
// state encoding, preamble constants and frame timing helper.
package seq_link_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

  localparam int PRE_W = 4;
  localparam logic [PRE_W-1:0] PREAMBLE_DEF = 4'b0011;

  // Wide enough to index the longest phase: 32 payload bits or 15 gap cycles.
  localparam int BIT_IDX_W = 5;

  // Accept-to-accept distance with data_valid held high.
  function automatic int frame_period(input int data_w, input int gap_len);
    return PRE_W + data_w + gap_len + 1;
  endfunction

endpackage

// File: rtl/seq_tx_shift.sv
// Payload register of the transmitter: parallel load, MSB-first left shift.
module seq_tx_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load_en,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              msb
);

  logic [DATA_W-1:0] sreg_q;
  logic [DATA_W-1:0] sreg_d;

  // NOTE: next-state logic assigns its default first, so every path drives sreg_d and no latch is inferred.
  always_comb begin
    sreg_d = sreg_q;
    if (load_en) begin
      sreg_d = data_in;
    end else if (shift_en) begin
      sreg_d = sreg_q << 1;
    end
  end

  // NOTE: state registers update with non-blocking assignments only; the payload register is
  // cleared on reset as well, so nothing of an aborted frame survives clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign msb = sreg_q[DATA_W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: valid/ready word in, preamble 0011 then payload
// MSB-first out on an idle-high line, with a forced idle gap between frames.
module seq_tx
  import seq_link_pkg::*;
#(
  parameter int               DATA_W   = 8,
  parameter logic [PRE_W-1:0] PREAMBLE = PREAMBLE_DEF,
  parameter int               GAP_LEN  = 2,
  parameter int               CNT_W    = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int                   PRE_SEL_W = $clog2(PRE_W);
  localparam logic [BIT_IDX_W-1:0] LAST_PRE  = BIT_IDX_W'(PRE_W - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_W - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_GAP  = BIT_IDX_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  tx_state_t            state_q, state_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic                 out_q, out_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 load_en;
  logic                 shift_en;
  logic                 shift_msb;
  logic [PRE_SEL_W-1:0] pre_sel;

  seq_tx_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .clr      (clr),
    .load_en  (load_en),
    .shift_en (shift_en),
    .data_in  (data_in),
    .msb      (shift_msb)
  );

  // Preamble bit for the next PRE cycle, sent bit PRE_W-1 first.
  assign pre_sel = PRE_SEL_W'(LAST_PRE - idx_q - BIT_IDX_W'(1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    out_d    = 1'b1;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    shift_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d = PRE;
          idx_d   = '0;
          out_d   = PREAMBLE[PRE_W-1];
          load_en = 1'b1;
        end
      end

      PRE: begin
        if (idx_q == LAST_PRE) begin
          state_d  = DATA;
          idx_d    = '0;
          out_d    = shift_msb;
          shift_en = 1'b1;
          done_d   = (LAST_BIT == '0);
        end else begin
          idx_d = idx_q + 1'b1;
          out_d = PREAMBLE[pre_sel];
        end
      end

      DATA: begin
        if (idx_q == LAST_BIT) begin
          // Bit 0 has just been on the line for its full cycle: frame complete.
          cnt_d   = cnt_q + 1'b1;
          idx_d   = '0;
          state_d = (GAP_LEN > 0) ? GAP : IDLE;
        end else begin
          idx_d    = idx_q + 1'b1;
          out_d    = shift_msb;
          shift_en = 1'b1;
          done_d   = ((idx_q + 1'b1) == LAST_BIT);
        end
      end

      GAP: begin
        if (idx_q == LAST_GAP) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Derived from state alone so that clr drops busy and raises ready at once.
  assign data_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out        = out_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: two instances (default config, and CNT_W=2 / GAP_LEN=0)
// checked each cycle against a queue-of-expected-line-bits model.
module tb_seq_tx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          clr_a, clr_b;
  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b;
  logic          ready_a, ready_b;
  logic          out_a, out_b;
  logic          busy_a, busy_b;
  logic          done_a, done_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  seq_tx #(.DATA_W(DW), .GAP_LEN(2), .CNT_W(8)) u_dut_a (
    .clk        (clk),
    .clr        (clr_a),
    .data_in    (data_a),
    .data_valid (valid_a),
    .data_ready (ready_a),
    .out        (out_a),
    .busy       (busy_a),
    .frame_done (done_a),
    .frame_cnt  (cnt_a)
  );

  seq_tx #(.DATA_W(DW), .GAP_LEN(0), .CNT_W(2)) u_dut_b (
    .clk        (clk),
    .clr        (clr_b),
    .data_in    (data_b),
    .data_valid (valid_b),
    .data_ready (ready_b),
    .out        (out_b),
    .busy       (busy_b),
    .frame_done (done_b),
    .frame_cnt  (cnt_b)
  );

  always #5 clk = ~clk;

  // One expected line cycle: the bit on out, and whether it is the last payload bit.
  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  typedef struct packed {
    logic [7:0]  word;
    logic [11:0] stream;
    logic [7:0]  cnt;
  } vec_t;

  exp_t       qa[$];
  exp_t       qb[$];
  int         cnta = 0;
  int         cntb = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cycle = 0;
  bit         acc_a, acc_b;
  logic [3:0] pre_v = 4'b0011;
  logic [3:0] det_hist = 4'b1111;
  bit         det_fire;
  bit         det_win = 1'b0;
  int         fires[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  // Whole frame as the line should show it, starting the cycle after accept.
  task automatic push_frame(input bit which, input logic [DW-1:0] w, input int gap);
    exp_t e;
    for (int i = 0; i < 4 + DW + gap; i++) begin
      if (i < 4) e = {pre_v[3-i], 1'b0};
      else if (i < 4 + DW) e = {w[DW-1-(i-4)], (i == 3 + DW)};
      else e = {1'b1, 1'b0};
      if (which) qb.push_back(e);
      else qa.push_back(e);
    end
  endtask

  // One clock: advance the model at the rising edge, compare on the falling edge.
  task automatic step();
    exp_t e;
    logic eo, eb, ed;
    @(posedge clk);
    acc_a = 1'b0;
    acc_b = 1'b0;
    if (clr_a) begin qa.delete(); cnta = 0; end
    else if (qa.size() != 0) begin e = qa.pop_front(); if (e.last) cnta++; end
    else if (valid_a) begin acc_a = 1'b1; push_frame(1'b0, data_a, 2); end
    if (clr_b) begin qb.delete(); cntb = 0; end
    else if (qb.size() != 0) begin e = qb.pop_front(); if (e.last) cntb++; end
    else if (valid_b) begin acc_b = 1'b1; push_frame(1'b1, data_b, 0); end
    @(negedge clk);
    cycle++;
    if (qa.size() == 0) begin eo = 1'b1; eb = 1'b0; ed = 1'b0; end
    else begin eo = qa[0].b; eb = 1'b1; ed = qa[0].last; end
    check("a.out",   32'(out_a),   32'(eo));
    check("a.busy",  32'(busy_a),  32'(eb));
    check("a.ready", 32'(ready_a), 32'(!eb));
    check("a.done",  32'(done_a),  32'(ed));
    check("a.cnt",   32'(cnt_a),   32'(cnta % 256));
    if (qb.size() == 0) begin eo = 1'b1; eb = 1'b0; ed = 1'b0; end
    else begin eo = qb[0].b; eb = 1'b1; ed = qb[0].last; end
    check("b.out",   32'(out_b),   32'(eo));
    check("b.busy",  32'(busy_b),  32'(eb));
    check("b.ready", 32'(ready_b), 32'(!eb));
    check("b.done",  32'(done_b),  32'(ed));
    check("b.cnt",   32'(cnt_b),   32'(cntb % 4));
    det_fire = (det_hist == 4'b0011);
    det_hist = {det_hist[2:0], out_a};
    if (det_win && det_fire) fires.push_back(cycle);
  endtask

  // Step until the model sees an accept; t is the cycle showing the first preamble bit.
  task automatic wait_acc(input bit which, output int t);
    t = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (which ? acc_b : acc_a) begin
        t = cycle;
        break;
      end
    end
    if (t < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout dut=%0d: no accept within 40 cycles, expected one", which);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int          t1, t2, prev;
    logic [11:0] got;
    vec_t        vecs[5];
    int          wrap_exp[5];

    vecs[0] = '{word: 8'hA5, stream: 12'b0011_1010_0101, cnt: 8'd2};
    vecs[1] = '{word: 8'hFF, stream: 12'b0011_1111_1111, cnt: 8'd3};
    vecs[2] = '{word: 8'h00, stream: 12'b0011_0000_0000, cnt: 8'd4};
    vecs[3] = '{word: 8'h3C, stream: 12'b0011_0011_1100, cnt: 8'd5};
    vecs[4] = '{word: 8'h81, stream: 12'b0011_1000_0001, cnt: 8'd6};
    wrap_exp = '{1, 2, 3, 0, 1};

    // Reset and idle line
    clr_a = 1'b1; clr_b = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    #1;
    check("rst_async.out",  32'(out_a),  32'd1);
    check("rst_async.busy", 32'(busy_a), 32'd0);
    repeat (3) step();
    clr_a = 1'b0; clr_b = 1'b0;
    repeat (20) step();
    check("idle.out",   32'(out_a),   32'd1);
    check("idle.ready", 32'(ready_a), 32'd1);
    check("idle.cnt",   32'(cnt_a),   32'd0);

    // Reset asserted asynchronously during payload bit 5
    data_a = 8'h5A; valid_a = 1'b1;
    wait_acc(1'b0, t1);
    valid_a = 1'b0;
    repeat (6) step();
    check("midrst.bit5", 32'(out_a),  32'd0);
    check("midrst.busy_before", 32'(busy_a), 32'd1);
    #1 clr_a = 1'b1;
    #1;
    check("midrst.out",   32'(out_a),   32'd1);
    check("midrst.busy",  32'(busy_a),  32'd0);
    check("midrst.ready", 32'(ready_a), 32'd1);
    check("midrst.cnt",   32'(cnt_a),   32'd0);
    qa.delete(); cnta = 0;
    step();
    clr_a = 1'b0;

    // Single frame 0xA5: stream, frame_done position, count, ready return
    data_a = 8'hA5; valid_a = 1'b1;
    wait_acc(1'b0, t1);
    valid_a = 1'b0; data_a = 8'h00;
    got[11] = out_a;
    check("a5.ready_low", 32'(ready_a), 32'd0);
    for (int i = 10; i >= 0; i--) begin
      step();
      got[i] = out_a;
      check("a5.done", 32'(done_a), 32'(i == 0));
    end
    check("a5.stream", 32'(got), 32'(12'b0011_1010_0101));
    for (int i = 0; i < 2; i++) begin
      step();
      check("a5.gap_out",  32'(out_a),  32'd1);
      check("a5.gap_busy", 32'(busy_a), 32'd1);
    end
    check("a5.cnt", 32'(cnt_a), 32'd1);
    step();
    check("a5.ready_back",  32'(ready_a),   32'd1);
    check("a5.ready_delay", 32'(cycle - t1), 32'd14);

    // Table of single frames
    for (int v = 0; v < 5; v++) begin
      data_a = vecs[v].word; valid_a = 1'b1;
      wait_acc(1'b0, t1);
      valid_a = 1'b0; data_a = 8'($urandom);
      got[11] = out_a;
      for (int i = 10; i >= 0; i--) begin
        step();
        got[i] = out_a;
      end
      check("tbl.done", 32'(done_a), 32'd1);
      check("tbl.stream", 32'(got), 32'(vecs[v].stream));
      repeat (3) step();
      check("tbl.cnt", 32'(cnt_a), 32'(vecs[v].cnt));
    end

    // Back-to-back 0xFF then 0x00 with a downstream 0011 detector watching
    fires.delete();
    det_win = 1'b1;
    data_a = 8'hFF; valid_a = 1'b1;
    wait_acc(1'b0, t1);
    data_a = 8'h00;
    wait_acc(1'b0, t2);
    valid_a = 1'b0;
    check("b2b.period", 32'(t2 - t1), 32'd15);
    repeat (11) step();
    det_win = 1'b0;
    check("b2b.fire_count", 32'(fires.size()), 32'd2);
    if (fires.size() == 2) begin
      check("b2b.fire0", 32'(fires[0]), 32'(t1 + 4));
      check("b2b.fire1", 32'(fires[1]), 32'(t2 + 4));
    end
    repeat (4) step();

    // data_valid raised while busy is not accepted until IDLE
    data_a = 8'h81; valid_a = 1'b1;
    wait_acc(1'b0, t1);
    valid_a = 1'b0;
    repeat (3) step();
    data_a = 8'h3C; valid_a = 1'b1;
    check("ign.ready_busy", 32'(ready_a), 32'd0);
    wait_acc(1'b0, t2);
    valid_a = 1'b0;
    check("ign.accept_at_idle", 32'(t2 - t1), 32'd15);
    got[11] = out_a;
    for (int i = 10; i >= 0; i--) begin
      step();
      got[i] = out_a;
    end
    check("ign.stream", 32'(got), 32'(12'b0011_0011_1100));
    repeat (4) step();
    check("ign.no_resend", 32'(busy_a), 32'd0);

    // Narrow counter, no gap: 5 back-to-back frames
    prev = 0;
    data_b = 8'($urandom); valid_b = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_acc(1'b1, t1);
      data_b = 8'($urandom);
      if (f == 4) valid_b = 1'b0;
      if (f > 0) check("wrap.period", 32'(t1 - prev), 32'd13);
      prev = t1;
      repeat (11) step();
      check("wrap.done", 32'(done_b), 32'd1);
      step();
      check("wrap.cnt",   32'(cnt_b),   32'(wrap_exp[f]));
      check("wrap.ready", 32'(ready_b), 32'd1);
    end

    // Random traffic on both instances, occasional resets
    for (int n = 0; n < 600; n++) begin
      step();
      if (acc_a) begin valid_a = 1'b0; data_a = 8'($urandom); end
      else if (!valid_a) begin
        data_a = 8'($urandom);
        if ($urandom_range(0, 2) == 0) valid_a = 1'b1;
      end
      if (acc_b) begin valid_b = 1'b0; data_b = 8'($urandom); end
      else if (!valid_b) begin
        data_b = 8'($urandom);
        if ($urandom_range(0, 2) == 0) valid_b = 1'b1;
      end
      if (clr_a) clr_a = 1'b0;
      else if ($urandom_range(0, 149) == 0) clr_a = 1'b1;
      if (clr_b) clr_b = 1'b0;
      else if ($urandom_range(0, 149) == 0) clr_b = 1'b1;
    end
    valid_a = 1'b0; valid_b = 1'b0;
    clr_a = 1'b0; clr_b = 1'b0;
    repeat (20) step();
    check("final.idle_a", 32'(busy_a), 32'd0);
    check("final.idle_b", 32'(busy_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
